// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand request in, result and status out.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (output start, a, b, carry_in, input  busy, done, sum, carry_out);
  modport slave  (input  start, a, b, carry_in, output busy, done, sum, carry_out);
endinterface

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, a registered carry, WIDTH cycles per sum.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_c;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {fa_c, fa_s} = full_add(a_sh_q[0], b_sh_q[0], c_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.carry_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        c_d    = fa_c;
        // Result fills from the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
        res_d  = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed/random scenarios plus an exhaustive WIDTH=3 sweep.
module tb_serial_adder;
  localparam int W8 = 8;
  localparam int W3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8)) bus8 ();
  serial_adder_if #(.WIDTH(W3)) bus3 ();

  serial_adder #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_adder #(.WIDTH(W3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int total = 0;
  int bad   = 0;

  task automatic drive8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.start = s; bus8.a = a; bus8.b = b; bus8.carry_in = c;
  endtask

  task automatic drive3(input logic s, input logic [2:0] a, input logic [2:0] b, input logic c);
    bus3.start = s; bus3.a = a; bus3.b = b; bus3.carry_in = c;
  endtask

  // Called at a negedge with start already driven; returns at the negedge where done is seen.
  // lat = samples after the accept edge until done (-1 on timeout).
  task automatic wait_done(input bit w3, output int lat, output int busy_cnt,
                           output bit overlap, output bit sum_moved);
    logic [7:0] s0;
    logic [7:0] s;
    lat = -1; busy_cnt = 0; overlap = 0; sum_moved = 0; s0 = '0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (w3) bus3.start = 1'b0; else bus8.start = 1'b0;
      end
      s = w3 ? {5'b0, bus3.sum} : bus8.sum;
      if (k == 0) s0 = s;
      if (w3 ? bus3.busy : bus8.busy) begin
        busy_cnt++;
        if (s !== s0) sum_moved = 1;
      end
      if ((w3 ? bus3.busy : bus8.busy) && (w3 ? bus3.done : bus8.done)) overlap = 1;
      if (w3 ? bus3.done : bus8.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] exp;
    int lat, bc;
    bit ov, sm;
    exp = 9'(a) + 9'(b) + 9'(c);
    drive8(1'b1, a, b, c);
    wait_done(1'b0, lat, bc, ov, sm);
    total++; if (lat !== W8) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, W8); end
    total++; if (bc !== W8) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, bc, W8); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL %s busy_done_overlap got=1 exp=0", nm); end
    total++; if (sm !== 1'b0) begin bad++; $display("FAIL %s sum_changed_while_busy got=1 exp=0", nm); end
    total++;
    if ({bus8.carry_out, bus8.sum} !== exp) begin
      bad++;
      $display("FAIL %s result got=%h exp=%h", nm, {bus8.carry_out, bus8.sum}, exp);
    end
  endtask

  task automatic test_reset;
    drive8(1'b0, '0, '0, 1'b0);
    drive3(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus8.done); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", bus8.sum); end
    total++; if (bus8.carry_out !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus8.carry_out); end
    total++;
    if ({bus3.busy, bus3.done, bus3.carry_out, bus3.sum} !== 6'b0) begin
      bad++;
      $display("FAIL reset_w3 got=%b exp=000000", {bus3.busy, bus3.done, bus3.carry_out, bus3.sum});
    end
  endtask

  task automatic test_basic;
    op8("basic_3c_0f", 8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    op8("basic_ff_01", 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    op8("basic_a5_5a", 8'hA5, 8'h5A, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int dones = 0;
    int lat = -1;
    drive8(1'b1, 8'h10, 8'h20, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) bus8.start = 1'b0;
      if (k == 3) drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
      if (k == 4) bus8.start = 1'b0;
      if (bus8.done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    total++; if (lat !== W8) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W8); end
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++;
    if ({bus8.carry_out, bus8.sum} !== 9'h030) begin
      bad++;
      $display("FAIL ignore_result got=%h exp=030", {bus8.carry_out, bus8.sum});
    end
  endtask

  task automatic test_back_to_back;
    int lat = -1;
    op8("b2b_first", 8'h12, 8'h34, 1'b0);
    drive8(1'b1, 8'h01, 8'h01, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    total++; if (bus8.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_next got=%b exp=1", bus8.busy); end
    total++; if (bus8.sum !== 8'h46) begin bad++; $display("FAIL b2b_sum_held got=%h exp=46", bus8.sum); end
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (bus8.done) begin lat = k; break; end
    end
    total++; if (lat !== W8) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, W8); end
    total++;
    if ({bus8.carry_out, bus8.sum} !== 9'h003) begin
      bad++;
      $display("FAIL b2b_result got=%h exp=003", {bus8.carry_out, bus8.sum});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus8.busy, bus8.done, bus8.carry_out, bus8.sum} !== 11'b0) begin
      bad++;
      $display("FAIL midreset_async got=%b exp=0", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midreset_spurious_done got=%0d exp=0", dones); end
    op8("midreset_rerun", 8'h80, 8'h80, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic c;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      op8($sformatf("random_%0d", i), a, b, c);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive3;
    logic [3:0] exp;
    logic [2:0] a, b;
    logic c;
    int lat, bc;
    bit ov, sm;
    time t_prev, t_now;
    t_prev = 0;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      a = 3'(i);
      b = 3'(i >> 3);
      c = 1'(i >> 6);
      exp = 4'(a) + 4'(b) + 4'(c);
      drive3(1'b1, a, b, c);
      wait_done(1'b1, lat, bc, ov, sm);
      t_now = $time;
      total++;
      if ({bus3.carry_out, bus3.sum} !== exp || lat !== W3 || ov) begin
        bad++;
        $display("FAIL exh3_%0d result got=%h lat=%0d exp=%h lat=%0d", i, {bus3.carry_out, bus3.sum}, lat, exp, W3);
      end
      if (i > 0) begin
        total++;
        if (t_now - t_prev !== 40) begin
          bad++;
          $display("FAIL exh3_%0d done_spacing got=%0t exp=40", i, t_now - t_prev);
        end
      end
      t_prev = t_now;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_exhaustive3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
